pulse_scheduler: RTL and testbench
==================================

PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters.
REQ-002 SHALL have parameter WIDTH_BITS, default 4: bit width of each pulse-width field.
REQ-003 SHALL have parameter GAP, default 1 (minimum 1): number of low cycles forced between pulses.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req, input, N_REQ bits: level request, one bit per requester.
REQ-007 SHALL have port pw, input, N_REQ*WIDTH_BITS bits: requester i's pulse width in cycles, in slice [i*WIDTH_BITS +: WIDTH_BITS].
REQ-008 SHALL have port signal, output, 1 bit: shared pulse line.
REQ-009 SHALL have port grant, output, N_REQ bits: one-hot owner of the current pulse.
REQ-010 SHALL have port done, output, N_REQ bits: one-cycle completion strobe to the owner.
REQ-011 SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, PULSE, GAP.
REQ-013 SHALL apply these actions at a rising edge in IDLE with req != 0:
- select the winner round-robin, searching upward from (last winner + 1) mod N_REQ;
- register grant one-hot;
- capture the winner's pw slice, with a value of 0 treated as 1;
- set signal=1 and enter PULSE.
REQ-014 SHALL hold signal high for exactly the captured width of cycles; later pw changes SHALL be ignored.
REQ-015 SHALL apply these actions at the edge ending the last PULSE cycle:
- set signal=0 and grant=0;
- set done bit of the winner =1 for one cycle;
- enter GAP.
REQ-016 SHALL remain in GAP for exactly GAP cycles with signal=0, then return to IDLE.
REQ-017 SHALL give a minimum request-to-request period of width+GAP+1 cycles; a single requester holding req SHALL receive back-to-back pulses at that period.
REQ-018 SHALL complete a pulse whose req is deasserted mid-pulse; no abort.
REQ-019 SHALL ignore req in PULSE and GAP; arbitration occurs only in IDLE.
REQ-020 SHALL keep grant and done one-hot or zero, and SHALL NOT assert both in the same cycle.
REQ-021 SHALL update the last-winner pointer only on a grant; with one active requester the pointer SHALL NOT skip it.
REQ-022 SHALL keep signal glitch-free, driven directly from a register.

Reset
REQ-023 SHALL apply these values when reset is high at a rising edge:
- state=IDLE, signal=0, grant=0, done=0, busy=0;
- width counter=0, gap counter=0;
- last-winner pointer=N_REQ-1, so requester 0 has first priority.
REQ-024 SHALL let reset during PULSE or GAP drop signal at that same edge, with no done strobe issued.
REQ-025 SHALL give reset priority over all other events at that edge.

Structure
REQ-026 SHALL place the state encoding (IDLE/PULSE/GAP) and default N_REQ, WIDTH_BITS and GAP constants in shared package pulse_sched_pkg.
REQ-027 SHALL implement round-robin selection in sub-module rr_arbiter:
- combinational;
- inputs req and pointer;
- output one-hot winner.
REQ-028 SHALL keep the FSM, counters and output registers in pulse_scheduler.

Verification
REQ-029 Single request: req=0001, pw0=3 -> signal high 3 cycles, grant=0001 during the pulse, done=0001 on the next cycle, busy low after 1 GAP cycle.
REQ-030 Contention: req=1111, pw slices all 2, held -> grants in order 0,1,2,3,0; each pulse 2 cycles, period 4 cycles.
REQ-031 Zero width: req=0100, pw2=0 -> signal high exactly 1 cycle, grant=0100, done=0100.
REQ-032 Mid-pulse changes: req0 with pw0=5, then req0 dropped and pw0 changed to 1 at pulse cycle 2 -> pulse still 5 cycles, done still issued.
REQ-033 Reset mid-pulse: reset at pulse cycle 2 of a pw=6 pulse -> signal=0, grant=0, done=0 at that edge; next req=1000 and 0001 together -> requester 0 granted first.
REQ-034 Continuous check: at most one grant bit and one done bit high, and signal high only while grant != 0.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the pulse scheduler.
package pulse_sched_pkg;

  localparam int unsigned DEF_N_REQ      = 4;
  localparam int unsigned DEF_WIDTH_BITS = 4;
  localparam int unsigned DEF_GAP        = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request above the
// last-winner pointer, wrapping around, and returns it one-hot.
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned PW    = idx_bits(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt
);

  logic          w_found;
  int unsigned   w_idx;

  // Scan requesters in priority order starting just above the pointer.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = (int'(i_ptr) + 1 + k) % N_REQ;
      if (!w_found && i_req[PW'(w_idx)]) begin
        o_gnt[PW'(w_idx)] = 1'b1;
        w_found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_scheduler.sv
// Shared-line pulse scheduler: arbitrates among requesters in IDLE, drives a
// registered pulse of the winner's captured width, then forces GAP low cycles.
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int unsigned N_REQ      = DEF_N_REQ,
  parameter int unsigned WIDTH_BITS = DEF_WIDTH_BITS,
  parameter int unsigned GAP        = DEF_GAP
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*WIDTH_BITS-1:0] pw,
  output logic                        signal,
  output logic [N_REQ-1:0]            grant,
  output logic [N_REQ-1:0]            done,
  output logic                        busy
);

  localparam int unsigned PW = idx_bits(N_REQ);
  localparam int unsigned GW = idx_bits(GAP);

  state_t                r_state, w_state_nxt;
  logic                  r_signal, w_signal_nxt;
  logic [N_REQ-1:0]      r_grant, w_grant_nxt;
  logic [N_REQ-1:0]      r_done, w_done_nxt;
  logic [WIDTH_BITS-1:0] r_cnt, w_cnt_nxt;
  logic [GW-1:0]         r_gcnt, w_gcnt_nxt;
  logic [PW-1:0]         r_last, w_last_nxt;

  logic [N_REQ-1:0]      w_win;
  logic [PW-1:0]         w_win_idx;
  logic [WIDTH_BITS-1:0] w_pw_sel;
  logic [WIDTH_BITS-1:0] w_cnt_load;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_arb (
    .i_req (req),
    .i_ptr (r_last),
    .o_gnt (w_win)
  );

  // Winner index and its pulse-width slice; a zero width behaves as one cycle.
  always_comb begin
    w_win_idx = '0;
    w_pw_sel  = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (w_win[j]) begin
        w_win_idx = PW'(j);
        w_pw_sel  = pw[j*WIDTH_BITS +: WIDTH_BITS];
      end
    end
    w_cnt_load = (w_pw_sel == '0) ? '0 : w_pw_sel - WIDTH_BITS'(1);
  end

  // Next-state and next-output logic; the counter holds remaining cycles minus one.
  always_comb begin
    w_state_nxt  = r_state;
    w_signal_nxt = r_signal;
    w_grant_nxt  = r_grant;
    w_done_nxt   = '0;
    w_cnt_nxt    = r_cnt;
    w_gcnt_nxt   = r_gcnt;
    w_last_nxt   = r_last;
    unique case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_grant_nxt  = w_win;
          w_signal_nxt = 1'b1;
          w_cnt_nxt    = w_cnt_load;
          w_last_nxt   = w_win_idx;
          w_state_nxt  = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_signal_nxt = 1'b0;
          w_grant_nxt  = '0;
          w_done_nxt   = r_grant;
          w_gcnt_nxt   = GW'(GAP - 1);
          w_state_nxt  = ST_GAP;
        end else begin
          w_cnt_nxt = r_cnt - WIDTH_BITS'(1);
        end
      end
      ST_GAP: begin
        if (r_gcnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gcnt_nxt = r_gcnt - GW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and output registers; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_signal <= 1'b0;
      r_grant  <= '0;
      r_done   <= '0;
      r_cnt    <= '0;
      r_gcnt   <= '0;
      r_last   <= PW'(N_REQ - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_signal <= w_signal_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gcnt   <= w_gcnt_nxt;
      r_last   <= w_last_nxt;
    end
  end

  assign signal = r_signal;
  assign grant  = r_grant;
  assign done   = r_done;
  assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler (N_REQ=4, WIDTH_BITS=4, GAP=1).
// Observation vector is {signal, busy, grant[3:0], done[3:0]}, sampled at negedge.
module tb_pulse_scheduler;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] pw;
  logic        signal;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  pulse_scheduler #(
    .N_REQ      (4),
    .WIDTH_BITS (4),
    .GAP        (1)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .pw     (pw),
    .signal (signal),
    .grant  (grant),
    .done   (done),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Invariants every cycle: one-hot-or-zero grant/done, never both, signal implies grant.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (($countones(grant) > 1) || ($countones(done) > 1) ||
          ((grant != 4'b0) && (done != 4'b0)) || (signal && (grant == 4'b0))) begin
        errors++;
        $display("FAIL invariant t=%0t: signal=%b grant=%b done=%b", $time, signal, grant, done);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [9:0] exp;
    reset = 1'b1;
    req   = 4'b0;
    pw    = 16'h0;
    tick();
    tick();
    exp = {1'b0, 1'b0, 4'b0000, 4'b0000};
    checks++;
    if ({signal, busy, grant, done} !== exp) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", {signal, busy, grant, done}, exp);
    end
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    logic [9:0] exp;
    req = 4'b0001;
    pw  = 16'h0003;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 0) req = 4'b0000;
      exp = {1'b1, 1'b1, 4'b0001, 4'b0000};
      checks++;
      if ({signal, busy, grant, done} !== exp) begin
        errors++;
        $display("FAIL single_pulse c%0d: got %b want %b", k, {signal, busy, grant, done}, exp);
      end
    end
    tick();
    exp = {1'b0, 1'b1, 4'b0000, 4'b0001};
    checks++;
    if ({signal, busy, grant, done} !== exp) begin
      errors++;
      $display("FAIL single_done: got %b want %b", {signal, busy, grant, done}, exp);
    end
    tick();
    exp = {1'b0, 1'b0, 4'b0000, 4'b0000};
    checks++;
    if ({signal, busy, grant, done} !== exp) begin
      errors++;
      $display("FAIL single_idle: got %b want %b", {signal, busy, grant, done}, exp);
    end
  endtask

  task automatic test_zero_width();
    logic [9:0] exp;
    req = 4'b0100;
    pw  = 16'h0000;
    tick();
    req = 4'b0000;
    exp = {1'b1, 1'b1, 4'b0100, 4'b0000};
    checks++;
    if ({signal, busy, grant, done} !== exp) begin
      errors++;
      $display("FAIL zero_pulse: got %b want %b", {signal, busy, grant, done}, exp);
    end
    tick();
    exp = {1'b0, 1'b1, 4'b0000, 4'b0100};
    checks++;
    if ({signal, busy, grant, done} !== exp) begin
      errors++;
      $display("FAIL zero_done: got %b want %b", {signal, busy, grant, done}, exp);
    end
    tick();
    exp = {1'b0, 1'b0, 4'b0000, 4'b0000};
    checks++;
    if ({signal, busy, grant, done} !== exp) begin
      errors++;
      $display("FAIL zero_idle: got %b want %b", {signal, busy, grant, done}, exp);
    end
  endtask

  task automatic test_contention();
    logic [9:0] exp;
    logic [3:0] g;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = 4'b1111;
    pw    = 16'h2222;
    for (int p = 0; p < 5; p++) begin
      g = 4'b0001 << (p % 4);
      for (int c = 0; c < 4; c++) begin
        tick();
        case (c)
          0, 1:    exp = {1'b1, 1'b1, g, 4'b0000};
          2:       exp = {1'b0, 1'b1, 4'b0000, g};
          default: exp = {1'b0, 1'b0, 4'b0000, 4'b0000};
        endcase
        checks++;
        if ({signal, busy, grant, done} !== exp) begin
          errors++;
          $display("FAIL contention p%0d c%0d: got %b want %b", p, c, {signal, busy, grant, done}, exp);
        end
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_mid_pulse_change();
    logic [9:0] exp;
    req = 4'b0001;
    pw  = 16'h0005;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 1) begin
        req = 4'b0000;
        pw  = 16'h0001;
      end
      exp = {1'b1, 1'b1, 4'b0001, 4'b0000};
      checks++;
      if ({signal, busy, grant, done} !== exp) begin
        errors++;
        $display("FAIL midpulse c%0d: got %b want %b", k, {signal, busy, grant, done}, exp);
      end
    end
    tick();
    exp = {1'b0, 1'b1, 4'b0000, 4'b0001};
    checks++;
    if ({signal, busy, grant, done} !== exp) begin
      errors++;
      $display("FAIL midpulse_done: got %b want %b", {signal, busy, grant, done}, exp);
    end
    tick();
    exp = {1'b0, 1'b0, 4'b0000, 4'b0000};
    checks++;
    if ({signal, busy, grant, done} !== exp) begin
      errors++;
      $display("FAIL midpulse_idle: got %b want %b", {signal, busy, grant, done}, exp);
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [9:0] exp;
    req = 4'b0001;
    pw  = 16'h0006;
    tick();
    req = 4'b0000;
    tick();
    exp = {1'b1, 1'b1, 4'b0001, 4'b0000};
    checks++;
    if ({signal, busy, grant, done} !== exp) begin
      errors++;
      $display("FAIL rstmid_pulse: got %b want %b", {signal, busy, grant, done}, exp);
    end
    reset = 1'b1;
    tick();
    exp = {1'b0, 1'b0, 4'b0000, 4'b0000};
    checks++;
    if ({signal, busy, grant, done} !== exp) begin
      errors++;
      $display("FAIL rstmid_drop: got %b want %b", {signal, busy, grant, done}, exp);
    end
    reset = 1'b0;
    req   = 4'b1001;
    pw    = 16'h1001;
    tick();
    exp = {1'b1, 1'b1, 4'b0001, 4'b0000};
    checks++;
    if ({signal, busy, grant, done} !== exp) begin
      errors++;
      $display("FAIL rstmid_first: got %b want %b", {signal, busy, grant, done}, exp);
    end
    tick();
    tick();
    tick();
    exp = {1'b1, 1'b1, 4'b1000, 4'b0000};
    checks++;
    if ({signal, busy, grant, done} !== exp) begin
      errors++;
      $display("FAIL rstmid_second: got %b want %b", {signal, busy, grant, done}, exp);
    end
    req = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0;
    pw    = 16'h0;
    test_reset();
    test_single();
    test_zero_width();
    test_contention();
    test_mid_pulse_change();
    test_reset_mid_pulse();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
